// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical memory port among NUM_CH cache channels.
// A winner is latched in IDLE and its strobe, address and data are held
// stable in BUSY until pmem_resp; the winner gets a one-cycle cmem_resp.
//
// Handshake: a channel raises cmem_read/cmem_write and holds its address/data
// until it sees its cmem_resp bit; it drops the request in the following
// cycle, otherwise that IDLE cycle sees it as a fresh request.
//
// Optional feature: define PMEM_ARB_RR_EN for round-robin arbitration
// (search starts at a pointer that moves past each winner); without it
// the lowest requesting index wins and no pointer register exists.
// dbg_state exposes the FSM state (0 = IDLE, 1 = BUSY).
module pmem_arbiter #(
   parameter int NUM_CH = 2,
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        cmem_read,
   input  logic [NUM_CH-1:0]        cmem_write,
   input  logic [NUM_CH*ADDR_W-1:0] cmem_address,
   input  logic [NUM_CH*LINE_W-1:0] cmem_wdata,
   output logic [NUM_CH-1:0]        cmem_resp,
   output logic [LINE_W-1:0]        cmem_rdata,
   output logic                     pmem_read,
   output logic                     pmem_write,
   output logic [ADDR_W-1:0]        pmem_address,
   output logic [LINE_W-1:0]        pmem_wdata,
   input  logic                     pmem_resp,
   input  logic [LINE_W-1:0]        pmem_rdata,
   output logic                     dbg_state
);

   localparam int GW = $clog2(NUM_CH);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     grant_q;
   logic [GW-1:0]     win_idx;
   logic              op_write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [NUM_CH-1:0] req;
   logic              req_any;
   logic              take;
   logic              win_write;
   logic [ADDR_W-1:0] win_addr;
   logic [LINE_W-1:0] win_wdata;

   assign req     = cmem_read | cmem_write;
   assign req_any = |req;

`ifdef PMEM_ARB_RR_EN
   logic [GW-1:0] rr_ptr_q;
   logic [GW:0]   cand;
   logic          found;

   // Round-robin pick: first requester at or after the pointer, wrapping.
   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, rr_ptr_q} + (GW+1)'(i);
         if (cand >= (GW+1)'(NUM_CH)) cand = cand - (GW+1)'(NUM_CH);
         if (!found && req[cand[GW-1:0]]) begin
            win_idx = cand[GW-1:0];
            found   = 1'b1;
         end
      end
   end

   // Pointer moves to the channel after each winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr_q <= '0;
      else if (take) rr_ptr_q <= (win_idx == GW'(NUM_CH-1)) ? '0 : win_idx + GW'(1);
   end
`else
   // Fixed priority pick: lowest requesting index wins.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (req[i]) win_idx = GW'(i);
      end
   end
`endif

   // Select the winner's operation, address and write line.
   always_comb begin
      win_write = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (win_idx == GW'(i)) begin
            win_write = cmem_write[i];  // read+write together resolves to write
            win_addr  = cmem_address[i*ADDR_W +: ADDR_W];
            win_wdata = cmem_wdata[i*LINE_W +: LINE_W];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: latch a winner in IDLE, finish on pmem_resp in BUSY.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               state_d = BUSY;
               take    = 1'b1;
            end
         end
         BUSY: begin
            if (pmem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Transaction registers: captured once per grant, frozen during BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q    <= '0;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else if (take) begin
         grant_q    <= win_idx;
         op_write_q <= win_write;
         addr_q     <= win_addr;
         wdata_q    <= win_wdata;
      end
   end

   // Completion pulse to the granted channel only while BUSY.
   always_comb begin
      cmem_resp = '0;
      if (state_q == BUSY && pmem_resp) cmem_resp[grant_q] = 1'b1;
   end

   assign pmem_read    = (state_q == BUSY) && !op_write_q;
   assign pmem_write   = (state_q == BUSY) &&  op_write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign cmem_rdata   = pmem_rdata;
   assign dbg_state    = (state_q == BUSY);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter with four channels: directed scenarios push the
// expected memory transactions and channel responses into queues, and a
// negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_pmem_arbiter;

   localparam int NUM_CH = 4;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
   localparam int GW     = 2;
   localparam int PMW    = 1 + ADDR_W + LINE_W;
   localparam int RSW    = GW + LINE_W;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_CH-1:0]        cmem_read;
   logic [NUM_CH-1:0]        cmem_write;
   logic [NUM_CH*ADDR_W-1:0] cmem_address;
   logic [NUM_CH*LINE_W-1:0] cmem_wdata;
   logic [NUM_CH-1:0]        cmem_resp;
   logic [LINE_W-1:0]        cmem_rdata;
   logic                     pmem_read;
   logic                     pmem_write;
   logic [ADDR_W-1:0]        pmem_address;
   logic [LINE_W-1:0]        pmem_wdata;
   logic                     pmem_resp;
   logic [LINE_W-1:0]        pmem_rdata;
   logic                     dbg_state;
   logic                     model_resp;
   logic                     inj_resp;

   int mem_lat;
   int n_checks;
   int n_fail;

   logic [PMW-1:0] exp_pm_q[$];
   logic [RSW-1:0] exp_resp_q[$];

   assign pmem_resp = model_resp | inj_resp;

   pmem_arbiter #(.NUM_CH(NUM_CH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmem_read(cmem_read), .cmem_write(cmem_write),
      .cmem_address(cmem_address), .cmem_wdata(cmem_wdata),
      .cmem_resp(cmem_resp), .cmem_rdata(cmem_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      if (a == 32'h0000_1000) return {32{8'hA5}};
      return {8{a ^ 32'h5A5A_0000}};
   endfunction

   function automatic logic [ADDR_W-1:0] addr_of(input int ch);
      return 32'h0000_0100 * (ch + 1);
   endfunction

   task automatic push_pm(input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
      exp_pm_q.push_back({wr, a, d});
   endtask

   task automatic push_resp(input logic [GW-1:0] ch, input logic [LINE_W-1:0] d);
      exp_resp_q.push_back({ch, d});
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int ch, input logic rd, input logic wr,
                          input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
      for (int i = 0; i < NUM_CH; i++) begin
         if (i == ch) begin
            cmem_read[i]  = rd;
            cmem_write[i] = wr;
            cmem_address[i*ADDR_W +: ADDR_W] = a;
            cmem_wdata[i*LINE_W +: LINE_W]   = d;
         end
      end
   endtask

   task automatic clr_req(input int ch);
      for (int i = 0; i < NUM_CH; i++) begin
         if (i == ch) begin
            cmem_read[i]  = 1'b0;
            cmem_write[i] = 1'b0;
         end
      end
   endtask

   // Wait (bounded) for n response pulses; returns at posedge+1 of the
   // cycle after the last pulse so the caller can drop its requests.
   task automatic wait_resps(input int n, input int max_cyc);
      int got;
      int cyc;
      got = 0;
      cyc = 0;
      while (got < n && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (cmem_resp != '0) got++;
      end
      n_checks++;
      if (got < n) begin
         n_fail++;
         $display("FAIL wait_resps: got %0d responses, expected %0d", got, n);
      end
      @(posedge clk); #1;
   endtask

   // ---------------- physical memory model ----------------
   initial begin : pmem_model
      int busy_cnt;
      busy_cnt   = 0;
      model_resp = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         model_resp = 1'b0;
         if (rst_n && (pmem_read || pmem_write)) begin
            busy_cnt++;
            if (busy_cnt == mem_lat + 1) begin
               model_resp = 1'b1;
               pmem_rdata = line_of(pmem_address);
               busy_cnt   = 0;
            end
         end else begin
            busy_cnt = 0;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      logic           strobe;
      logic           prev_strobe;
      logic [PMW-1:0] obs;
      logic [PMW-1:0] cur_pm;
      logic [RSW-1:0] er;
      logic [NUM_CH-1:0] oh;
      prev_strobe = 1'b0;
      cur_pm      = '0;
      forever begin
         @(negedge clk);
         strobe = pmem_read | pmem_write;
         obs    = {pmem_write, pmem_address, pmem_wdata};
         check("strobe_excl", pmem_read & pmem_write, 0);
         check("resp_onehot", $onehot0(cmem_resp), 1);
         check("rdata_follow", cmem_rdata, pmem_rdata);
         if (strobe && !prev_strobe) begin
            if (exp_pm_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pm_unexpected: got txn %0h, expected none", obs);
            end else begin
               cur_pm = exp_pm_q.pop_front();
               check("pm_txn", obs, cur_pm);
            end
         end else if (strobe) begin
            check("pm_stable", obs, cur_pm);
         end
         if (cmem_resp != '0) begin
            if (exp_resp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL resp_unexpected: got cmem_resp %0b, expected none", cmem_resp);
            end else begin
               er = exp_resp_q.pop_front();
               oh = '0;
               oh[er[RSW-1:LINE_W]] = 1'b1;
               check("resp_ch", cmem_resp, oh);
               check("resp_rdata", cmem_rdata, er[LINE_W-1:0]);
            end
         end
         prev_strobe = strobe;
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin : stim
      logic [LINE_W-1:0] w0;
      logic [LINE_W-1:0] w1;
      int ch;
      n_checks     = 0;
      n_fail       = 0;
      mem_lat      = 1;
      inj_resp     = 1'b0;
      cmem_read    = '0;
      cmem_write   = '0;
      cmem_address = '0;
      cmem_wdata   = '0;
      rst_n        = 1'b0;
      w0 = {8{32'hC0DE_2000}};
      w1 = {8{32'h1111_3000}};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_pmem_read", pmem_read, 0);
      check("rst_pmem_write", pmem_write, 0);
      check("rst_pmem_address", pmem_address, 0);
      check("rst_pmem_wdata", pmem_wdata, 0);
      check("rst_cmem_resp", cmem_resp, 0);
      check("rst_state", dbg_state, 0);
      rst_n = 1'b1;

      // pmem_resp while IDLE is ignored
      @(posedge clk); #1;
      inj_resp = 1'b1;
      @(negedge clk);
      check("idle_resp", cmem_resp, 0);
      check("idle_state", dbg_state, 0);
      @(posedge clk); #1;
      inj_resp = 1'b0;

      // channel 1 read of 0x1000, memory answers after 3 cycles
      mem_lat = 3;
      push_pm(1'b0, 32'h0000_1000, '0);
      push_resp(2'd1, {32{8'hA5}});
      set_req(1, 1'b1, 1'b0, 32'h0000_1000, '0);
      @(negedge clk);
      check("a_cycle0_read", pmem_read, 0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check("a_read_high", pmem_read, 1);
         check("a_resp_timing", cmem_resp, (c == 4) ? 4'b0010 : 4'b0000);
      end
      check("a_rdata", cmem_rdata, {32{8'hA5}});
      @(posedge clk); #1;
      clr_req(1);
      @(negedge clk);
      check("a_back_idle", pmem_read, 0);

      // channels 0 and 1 read continuously
      mem_lat = 1;
      for (int t = 0; t < 4; t++) begin
`ifdef PMEM_ARB_RR_EN
         ch = t % 2;
`else
         ch = 0;
`endif
         push_pm(1'b0, addr_of(ch), '0);
         push_resp(GW'(ch), line_of(addr_of(ch)));
      end
      set_req(0, 1'b1, 1'b0, addr_of(0), '0);
      set_req(1, 1'b1, 1'b0, addr_of(1), '0);
      wait_resps(4, 40);
      clr_req(0);
      clr_req(1);

      // channel 0 read+write (resolves to write) while channel 1 moves its address
      mem_lat = 3;
      push_pm(1'b1, 32'h0000_2000, w0);
      push_resp(2'd0, line_of(32'h0000_2000));
      push_pm(1'b0, 32'h0000_3100, w1);
      push_resp(2'd1, line_of(32'h0000_3100));
      set_req(0, 1'b1, 1'b1, 32'h0000_2000, w0);
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'b0, 32'h0000_3000, w1);
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'b0, 32'h0000_3100, w1);
      @(negedge clk);
      check("c_addr_held", pmem_address, 32'h0000_2000);
      check("c_write_held", pmem_write, 1);
      wait_resps(1, 20);
      clr_req(0);
      wait_resps(1, 20);
      clr_req(1);

      // reset during BUSY aborts the transaction, late pmem_resp ignored
      mem_lat = 6;
      push_pm(1'b0, 32'h0000_4000, '0);
      set_req(2, 1'b1, 1'b0, 32'h0000_4000, '0);
      @(negedge clk);
      @(negedge clk);
      check("d_busy_read", pmem_read, 1);
      rst_n = 1'b0;
      #1;
      check("d_rst_read", pmem_read, 0);
      check("d_rst_state", dbg_state, 0);
      check("d_rst_address", pmem_address, 0);
      clr_req(2);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      inj_resp = 1'b1;
      @(negedge clk);
      check("d_late_resp", cmem_resp, 0);
      check("d_late_read", pmem_read, 0);
      check("d_late_state", dbg_state, 0);
      @(posedge clk); #1;
      inj_resp = 1'b0;

      // all four channels request continuously
      mem_lat = 1;
      for (int t = 0; t < 5; t++) begin
`ifdef PMEM_ARB_RR_EN
         ch = t % 4;
`else
         ch = 0;
`endif
         push_pm(1'b0, addr_of(ch), '0);
         push_resp(GW'(ch), line_of(addr_of(ch)));
      end
      for (int i = 0; i < NUM_CH; i++) set_req(i, 1'b1, 1'b0, addr_of(i), '0);
      wait_resps(5, 60);
      for (int i = 0; i < NUM_CH; i++) clr_req(i);

      repeat (4) @(negedge clk);
      check("pm_queue_drained", exp_pm_q.size(), 0);
      check("resp_queue_drained", exp_resp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
